// File: rtl/regfile_pkg.sv
// Shared types and limits for the register-file write sequencer: FSM states,
// queue entry layout, phase counter width and the legal parameter ranges.
package regfile_pkg;

    localparam int ADDR_W    = 2;
    localparam int DATA_W    = 8;
    localparam int NUM_REGS  = 4;
    localparam int PHASE_W   = 4;
    localparam int PHASE_MIN = 1;
    localparam int PHASE_MAX = 15;
    localparam int DEPTH_MIN = 2;
    localparam int DEPTH_MAX = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } wr_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

    // Terminal value of the phase counter for a phase lasting 'cycles' cycles.
    function automatic logic [PHASE_W-1:0] phase_last(input int cycles);
        return PHASE_W'(cycles - 1);
    endfunction

    function automatic bit params_ok(input int setup_c, input int strobe_c,
                                     input int hold_c, input int depth);
        bit ok;
        ok = (setup_c  >= PHASE_MIN) && (setup_c  <= PHASE_MAX) &&
             (strobe_c >= PHASE_MIN) && (strobe_c <= PHASE_MAX) &&
             (hold_c   >= PHASE_MIN) && (hold_c   <= PHASE_MAX) &&
             (depth >= DEPTH_MIN) && (depth <= DEPTH_MAX) &&
             ((depth & (depth - 1)) == 0);
        return ok;
    endfunction

endpackage

// File: rtl/regfile_wr_fifo.sv
// Write-request queue: DEPTH entries, power-of-two pointers that wrap naturally,
// exposes the head entry and the one behind it so a pop can chain straight on.
module regfile_wr_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_push,
    input  logic [ADDR_W+DATA_W-1:0]    i_push_entry,
    input  logic                        i_pop,
    output logic [ADDR_W+DATA_W-1:0]    o_head,
    output logic [ADDR_W+DATA_W-1:0]    o_next,
    output logic                        o_full,
    output logic                        o_empty,
    output logic [$clog2(DEPTH):0]      o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wr_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_do_push;
    logic             w_do_pop;
    logic [PTR_W-1:0] w_rd_next;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign w_rd_next = r_rd_ptr + 1'b1;
    assign o_head    = r_mem[r_rd_ptr];
    assign o_next    = r_mem[w_rd_next];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= w_rd_next;
            end
            // Push and pop together leave the occupancy unchanged.
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; only entries between the pointers are ever read.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_entry;
        end
    end

endmodule

// File: rtl/regfile_writer.sv
// Queues write requests and replays each as a setup/strobe/hold sequence on the
// active-low register-file write port. Optional REGFILE_WRITER_PENDING_EN adds per-register pending flags.
module regfile_writer
    import regfile_pkg::*;
#(
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 1,
    parameter int HOLD_CYCLES   = 1,
    parameter int DEPTH         = 4
) (
    input  logic       clk,
    input  logic       _reset_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_addr,
    input  logic [7:0] in_data,
    output logic       wr_en,
    output logic [1:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy,
    output logic [3:0] pending
);

    localparam int                 CNT_W       = $clog2(DEPTH) + 1;
    localparam logic [PHASE_W-1:0] SETUP_LAST  = phase_last(SETUP_CYCLES);
    localparam logic [PHASE_W-1:0] STROBE_LAST = phase_last(STROBE_CYCLES);
    localparam logic [PHASE_W-1:0] HOLD_LAST   = phase_last(HOLD_CYCLES);

    if (!params_ok(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES, DEPTH)) begin : g_param_err
        $error("regfile_writer: timing or depth parameter out of range");
    end

    wr_state_t          r_state;
    logic [PHASE_W-1:0] r_phase;
    logic               r_wr_en;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [DATA_W-1:0]  r_wr_data;
    logic               r_rst_done;

    logic               w_push;
    logic               w_pop;
    logic               w_more;
    wr_entry_t          w_push_entry;
    wr_entry_t          w_head;
    wr_entry_t          w_next;
    logic               w_full;
    logic               w_empty;
    logic [CNT_W-1:0]   w_count;

    // Readiness comes only from registered state, so a same-cycle pop never opens a full queue.
    assign in_ready     = r_rst_done && !w_full;
    assign w_push       = in_valid && in_ready;
    assign w_pop        = (r_state == HOLD) && (r_phase == HOLD_LAST);
    assign w_more       = (w_count > CNT_W'(1));
    assign w_push_entry = '{addr: in_addr, data: in_data};

    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign busy    = (r_state != IDLE) || !w_empty;

    regfile_wr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk        (clk),
        .i_rst_n      (_reset_n),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .o_head       (w_head),
        .o_next       (w_next),
        .o_full       (w_full),
        .o_empty      (w_empty),
        .o_count      (w_count)
    );

    always_ff @(posedge clk) begin
        r_rst_done <= _reset_n;
    end

    always_ff @(posedge clk) begin
        if (!_reset_n) begin
            r_state   <= IDLE;
            r_phase   <= '0;
            r_wr_en   <= 1'b1;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_state   <= SETUP;
                        r_phase   <= '0;
                        r_wr_addr <= w_head.addr;
                        r_wr_data <= w_head.data;
                    end
                end
                SETUP: begin
                    if (r_phase == SETUP_LAST) begin
                        r_state <= STROBE;
                        r_phase <= '0;
                        r_wr_en <= 1'b0;
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
                STROBE: begin
                    if (r_phase == STROBE_LAST) begin
                        r_state <= HOLD;
                        r_phase <= '0;
                        r_wr_en <= 1'b1;
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
                HOLD: begin
                    if (r_phase == HOLD_LAST) begin
                        r_phase <= '0;
                        // Chain directly into the entry behind the one being popped.
                        if (w_more) begin
                            r_state   <= SETUP;
                            r_wr_addr <= w_next.addr;
                            r_wr_data <= w_next.data;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_phase <= '0;
                    r_wr_en <= 1'b1;
                end
            endcase
        end
    end

`ifdef REGFILE_WRITER_PENDING_EN
    logic [CNT_W-1:0] r_pend_cnt [NUM_REGS];
    logic             w_pend_inc [NUM_REGS];
    logic             w_pend_dec [NUM_REGS];

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            w_pend_inc[r] = w_push && (in_addr == ADDR_W'(r));
            w_pend_dec[r] = w_pop && (w_head.addr == ADDR_W'(r));
            pending[r]    = (r_pend_cnt[r] != '0);
        end
    end

    // One counter per register: entries targeting it from push until pop.
    always_ff @(posedge clk) begin
        for (int r = 0; r < NUM_REGS; r++) begin
            if (!_reset_n) begin
                r_pend_cnt[r] <= '0;
            end else if (w_pend_inc[r] && !w_pend_dec[r]) begin
                r_pend_cnt[r] <= r_pend_cnt[r] + 1'b1;
            end else if (w_pend_dec[r] && !w_pend_inc[r]) begin
                r_pend_cnt[r] <= r_pend_cnt[r] - 1'b1;
            end
        end
    end
`else
    assign pending = 4'b0000;
`endif

endmodule

// File: tb/tb_regfile_writer.sv
// Bench for regfile_writer: a default instance and a stretched-timing, depth-2 instance,
// both checked every cycle against a schedule computed from the write timing rules.
`timescale 1ns/1ps
module tb_regfile_writer;

    localparam int NU = 2;
    localparam int MAXS = 512;

    typedef struct packed {
        int         a;
        int         s;
        logic [1:0] addr;
        logic [7:0] data;
    } sched_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       vld    [NU];
    logic [1:0] adr    [NU];
    logic [7:0] dat    [NU];
    logic       rdy_w  [NU];
    logic       wen_w  [NU];
    logic [1:0] wadr_w [NU];
    logic [7:0] wdat_w [NU];
    logic       busy_w [NU];
    logic [3:0] pend_w [NU];

    regfile_writer u_dut0 (
        .clk(clk), ._reset_n(rst_n), .in_valid(vld[0]), .in_ready(rdy_w[0]),
        .in_addr(adr[0]), .in_data(dat[0]), .wr_en(wen_w[0]), .wr_addr(wadr_w[0]),
        .wr_data(wdat_w[0]), .busy(busy_w[0]), .pending(pend_w[0])
    );

    regfile_writer #(
        .SETUP_CYCLES(2), .STROBE_CYCLES(3), .HOLD_CYCLES(1), .DEPTH(2)
    ) u_dut1 (
        .clk(clk), ._reset_n(rst_n), .in_valid(vld[1]), .in_ready(rdy_w[1]),
        .in_addr(adr[1]), .in_data(dat[1]), .wr_en(wen_w[1]), .wr_addr(wadr_w[1]),
        .wr_data(wdat_w[1]), .busy(busy_w[1]), .pending(pend_w[1])
    );

    // Reference model state
    sched_t     sched    [NU][MAXS];
    int         n_sched  [NU];
    int         last_end [NU];
    bit         rdy_en   [NU];
    bit         exp_rdy  [NU];
    bit         exp_wen  [NU];
    bit         exp_busy [NU];
    bit         prev_wen [NU];
    bit         accepted [NU];
    logic [9:0] exp_q    [NU][$];
    logic [9:0] req_q    [NU][$];

    int cyc;
    int errors;
    int checks;
    int gap_pct;

    function automatic int t_setup(input int u);  return (u == 0) ? 1 : 2; endfunction
    function automatic int t_strobe(input int u); return (u == 0) ? 1 : 3; endfunction
    function automatic int t_hold(input int u);   return 1;                endfunction
    function automatic int t_depth(input int u);  return (u == 0) ? 4 : 2; endfunction
    function automatic int t_total(input int u);
        return t_setup(u) + t_strobe(u) + t_hold(u);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Edge-time bookkeeping: reset, or acceptance scheduled after the previous write ends.
    task automatic model_edge();
        for (int u = 0; u < NU; u++) begin
            accepted[u] = 1'b0;
            if (!rst_n) begin
                n_sched[u]  = 0;
                last_end[u] = 0;
                rdy_en[u]   = 1'b0;
                exp_q[u].delete();
                req_q[u].delete();
            end else begin
                if (vld[u] && exp_rdy[u]) begin
                    int s;
                    s = (cyc + 1 > last_end[u]) ? cyc + 1 : last_end[u];
                    if (n_sched[u] >= MAXS) begin
                        $display("FAIL model_overflow u%0d", u);
                        $fatal(1);
                    end
                    sched[u][n_sched[u]] = '{a: cyc, s: s, addr: adr[u], data: dat[u]};
                    n_sched[u]++;
                    last_end[u] = s + t_total(u);
                    exp_q[u].push_back({adr[u], dat[u]});
                    void'(req_q[u].pop_front());
                    accepted[u] = 1'b1;
                end
                rdy_en[u] = 1'b1;
            end
        end
    endtask

    task automatic model_check();
        for (int u = 0; u < NU; u++) begin
            int         occ;
            int         best;
            bit         ewen;
            logic [1:0] ea;
            logic [7:0] ed;
            logic [3:0] ep;
            logic [9:0] ent;
            occ = 0; best = -1; ewen = 1'b1; ea = '0; ed = '0; ep = '0;
            for (int i = 0; i < n_sched[u]; i++) begin
                sched_t sc;
                sc = sched[u][i];
                if (sc.s <= cyc && sc.s > best) begin
                    best = sc.s;
                    ea   = sc.addr;
                    ed   = sc.data;
                end
                if (cyc >= sc.s + t_setup(u) && cyc < sc.s + t_setup(u) + t_strobe(u)) ewen = 1'b0;
                if (sc.s + t_total(u) > cyc) begin
                    occ++;
                    ep[sc.addr] = 1'b1;
                end
            end
`ifndef REGFILE_WRITER_PENDING_EN
            ep = 4'b0000;
`endif
            exp_rdy[u]  = rdy_en[u] && (occ < t_depth(u));
            exp_busy[u] = (occ > 0);
            exp_wen[u]  = ewen;
            check($sformatf("u%0d.wr_en", u),    32'(wen_w[u]),  32'(ewen));
            check($sformatf("u%0d.wr_addr", u),  32'(wadr_w[u]), 32'(ea));
            check($sformatf("u%0d.wr_data", u),  32'(wdat_w[u]), 32'(ed));
            check($sformatf("u%0d.busy", u),     32'(busy_w[u]), 32'(exp_busy[u]));
            check($sformatf("u%0d.in_ready", u), 32'(rdy_w[u]),  32'(exp_rdy[u]));
            check($sformatf("u%0d.pending", u),  32'(pend_w[u]), 32'(ep));
            if (!wen_w[u] && prev_wen[u]) begin
                check($sformatf("u%0d.strobe_expected", u), 32'(exp_q[u].size() > 0), 32'd1);
                if (exp_q[u].size() > 0) begin
                    ent = exp_q[u].pop_front();
                    check($sformatf("u%0d.strobe_order", u), 32'({wadr_w[u], wdat_w[u]}), 32'(ent));
                end
            end
            prev_wen[u] = wen_w[u];
        end
    endtask

    task automatic drive();
        for (int u = 0; u < NU; u++) begin
            if (req_q[u].size() == 0) begin
                vld[u] = 1'b0;
            end else if (vld[u] && !accepted[u]) begin
                vld[u] = 1'b1;
            end else if ($urandom_range(99, 0) >= gap_pct) begin
                vld[u] = 1'b1;
                {adr[u], dat[u]} = req_q[u][0];
            end else begin
                vld[u] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
        model_check();
        drive();
    endtask

    task automatic send(input logic [1:0] a, input logic [7:0] d);
        for (int u = 0; u < NU; u++) req_q[u].push_back({a, d});
    endtask

    task automatic wait_idle(input string tag, input int max_cycles);
        bit done;
        done = 1'b0;
        for (int n = 0; n < max_cycles && !done; n++) begin
            tick();
            done = (req_q[0].size() == 0) && (req_q[1].size() == 0) &&
                   !exp_busy[0] && !exp_busy[1] && !vld[0] && !vld[1];
        end
        check({tag, ".idle_reached"}, 32'(done), 32'd1);
    endtask

    initial begin
        bit found;
        cyc = 0; errors = 0; checks = 0; gap_pct = 0;
        rst_n = 1'b0;
        for (int u = 0; u < NU; u++) begin
            vld[u] = 1'b0; adr[u] = '0; dat[u] = '0;
            n_sched[u] = 0; last_end[u] = 0; rdy_en[u] = 1'b0;
            exp_rdy[u] = 1'b0; exp_wen[u] = 1'b1; exp_busy[u] = 1'b0;
            prev_wen[u] = 1'b1; accepted[u] = 1'b0;
        end

        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Lone write, then four back-to-back, then five against a 4-deep queue
        send(2'd2, 8'hA5);
        wait_idle("single", 30);
        send(2'd0, 8'h11); send(2'd1, 8'h22); send(2'd2, 8'h33); send(2'd3, 8'h44);
        wait_idle("b2b", 60);
        for (int i = 0; i < 5; i++) send(2'(i), 8'(8'hC0 + i));
        wait_idle("full", 80);
        send(2'd1, 8'h5A); send(2'd1, 8'h6B);
        wait_idle("pend_same", 40);

        // Reset while the default instance is in its strobe with entries still queued
        send(2'd3, 8'hE1); send(2'd0, 8'hE2); send(2'd1, 8'hE3);
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            tick();
            found = !exp_wen[0];
        end
        check("rst_mid.strobe_seen", 32'(found), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (12) tick();

        // Randomized traffic, sparse then saturating
        for (int pass = 0; pass < 2; pass++) begin
            gap_pct = (pass == 0) ? 40 : 0;
            for (int i = 0; i < 60; i++) begin
                send(2'($urandom_range(3, 0)), 8'($urandom_range(255, 0)));
            end
            wait_idle($sformatf("rand%0d", pass), 600);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1);
    end

endmodule
